// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states and default widths.
package hazard_ctrl_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int CNT_W      = 16;
   localparam int JCNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      JUMP     = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_stall_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module stall_counter
   import hazard_ctrl_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: jump flush stalls, load-use and memory-wait freezes, stall statistics.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int JUMP_PENALTY = 2,
   parameter int REG_AW       = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              jump_req,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              mem_busy,
   output logic              jump_stall,
   output logic              full_stall,
   output logic [CNT_W-1:0]  stall_cycles
);

   // jcnt holds the JUMP-state cycles still owed, counting the current one
   localparam logic [JCNT_W-1:0] JCNT_INIT = JCNT_W'(JUMP_PENALTY - 1);

   hz_state_e         state, state_nx;
   logic [JCNT_W-1:0] jcnt, jcnt_nx, jcnt_dec;
   logic              jump_pend, jump_pend_nx;
   logic              load_use;
   logic              js_c, fs_c;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   assign jcnt_dec = (jcnt == '0) ? '0 : jcnt - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         jcnt      <= '0;
         jump_pend <= 1'b0;
      end else begin
         state     <= state_nx;
         jcnt      <= jcnt_nx;
         jump_pend <= jump_pend_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      jcnt_nx      = jcnt;
      jump_pend_nx = jump_pend;
      js_c         = 1'b0;
      fs_c         = mem_busy;
      case (state)
         IDLE: begin
            // a jump flushes the ID instruction, so its load-use hazard is moot
            fs_c = mem_busy || (load_use && !jump_req);
            if (mem_busy) begin
               state_nx     = MEM_WAIT;
               jump_pend_nx = jump_req;
            end else if (jump_req) begin
               js_c = 1'b1;
               if (JCNT_INIT != '0) begin
                  state_nx = JUMP;
                  jcnt_nx  = JCNT_INIT;
               end
            end
         end
         JUMP: begin
            js_c = 1'b1;
            if (jump_req) begin
               jcnt_nx  = JCNT_INIT;
               state_nx = (JCNT_INIT == '0) ? IDLE : JUMP;
            end else begin
               jcnt_nx  = jcnt_dec;
               state_nx = (jcnt_dec == '0) ? IDLE : JUMP;
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               jump_pend_nx = jump_pend || jump_req;
            end else begin
               jump_pend_nx = 1'b0;
               state_nx     = IDLE;
               // a jump seen while memory was busy starts its penalty now
               if (jump_pend || jump_req) begin
                  js_c = 1'b1;
                  if (JCNT_INIT != '0) begin
                     state_nx = JUMP;
                     jcnt_nx  = JCNT_INIT;
                  end
               end
            end
         end
         default: begin
            state_nx     = IDLE;
            jcnt_nx      = '0;
            jump_pend_nx = 1'b0;
         end
      endcase
   end

   assign jump_stall = rst_n && js_c;
   assign full_stall = rst_n && fs_c;

   stall_counter #(
      .W (CNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (jump_stall || full_stall),
      .count (stall_cycles)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_hazard_ctrl;

   localparam int JP = 2;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          jump_req = 1'b0;
   logic          ex_mem_read = 1'b0;
   logic [AW-1:0] ex_rd = '0;
   logic [AW-1:0] id_rs1 = '0;
   logic [AW-1:0] id_rs2 = '0;
   logic          mem_busy = 1'b0;
   logic          jump_stall;
   logic          full_stall;
   logic [15:0]   stall_cycles;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: owed jump-stall cycles, memory-wait phase, pending jump, stall total
   int m_jleft;
   bit m_wait;
   bit m_pend;
   int m_count;
   bit e_js;
   bit e_fs;

   hazard_ctrl #(
      .JUMP_PENALTY (JP),
      .REG_AW       (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .jump_req     (jump_req),
      .ex_mem_read  (ex_mem_read),
      .ex_rd        (ex_rd),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .mem_busy     (mem_busy),
      .jump_stall   (jump_stall),
      .full_stall   (full_stall),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic model_reset();
      m_jleft = 0;
      m_wait  = 1'b0;
      m_pend  = 1'b0;
      m_count = 0;
   endtask

   task automatic model_eval();
      bit lu;
      lu = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      if (m_wait) begin
         e_js = !mem_busy && (m_pend || jump_req);
         e_fs = mem_busy;
      end else if (m_jleft > 0) begin
         e_js = 1'b1;
         e_fs = mem_busy;
      end else begin
         e_js = jump_req && !mem_busy;
         e_fs = mem_busy || (lu && !jump_req);
      end
   endtask

   task automatic model_commit();
      if ((e_js || e_fs) && m_count < 65535) m_count++;
      if (m_wait) begin
         if (mem_busy) m_pend = m_pend || jump_req;
         else begin
            if (m_pend || jump_req) m_jleft = JP - 1;
            m_wait = 1'b0;
            m_pend = 1'b0;
         end
      end else if (m_jleft > 0) begin
         if (jump_req) m_jleft = JP - 1;
         else m_jleft--;
      end else if (mem_busy) begin
         m_wait = 1'b1;
         m_pend = jump_req;
      end else if (jump_req) begin
         m_jleft = JP - 1;
      end
   endtask

   // called one time unit after a rising edge; leaves inputs settled for sampling
   task automatic set_in(input bit jr, input bit rd, input logic [AW-1:0] erd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2, input bit busy);
      jump_req    = jr;
      ex_mem_read = rd;
      ex_rd       = erd;
      id_rs1      = r1;
      id_rs2      = r2;
      mem_busy    = busy;
      #1;
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic test_reset();
      set_in(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1);
      n_checks++;
      if ({jump_stall, full_stall} !== 2'b00)
         $display("FAIL reset_outputs: got js/fs=%b, required 00", {jump_stall, full_stall});
      else n_pass++;
      n_checks++;
      if (stall_cycles !== 16'd0)
         $display("FAIL reset_count: got %0d, required 0", stall_cycles);
      else n_pass++;
      @(posedge clk);
      #1;
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 10; c++) begin
         #1;
         n_checks++;
         if ({jump_stall, full_stall} !== 2'b00)
            $display("FAIL idle_outputs: cycle %0d got js/fs=%b, required 00", c, {jump_stall, full_stall});
         else n_pass++;
         tick();
      end
      n_checks++;
      if (stall_cycles !== 16'd0)
         $display("FAIL idle_count: got %0d, required 0", stall_cycles);
      else n_pass++;
   endtask

   task automatic test_jump_pulse();
      bit exp_js [0:7] = '{0, 0, 0, 0, 0, 1, 1, 0};
      for (int c = 0; c < 8; c++) begin
         set_in(c == 5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         n_checks++;
         if ({jump_stall, full_stall} !== {exp_js[c], 1'b0})
            $display("FAIL jump_pulse: cycle %0d got js/fs=%b, required %b%b", c,
                     {jump_stall, full_stall}, exp_js[c], 1'b0);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (stall_cycles !== 16'd2)
         $display("FAIL jump_pulse_count: got %0d, required 2", stall_cycles);
      else n_pass++;
   endtask

   task automatic test_load_use();
      set_in(1'b0, 1'b1, 5'd3, 5'd1, 5'd3, 1'b0);
      n_checks++;
      if ({jump_stall, full_stall} !== 2'b01)
         $display("FAIL load_use_rs2: got js/fs=%b, required 01", {jump_stall, full_stall});
      else n_pass++;
      tick();
      set_in(1'b0, 1'b0, 5'd3, 5'd1, 5'd3, 1'b0);
      n_checks++;
      if (full_stall !== 1'b0)
         $display("FAIL load_use_drop: got %b, required 0", full_stall);
      else n_pass++;
      tick();
      set_in(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
      n_checks++;
      if (full_stall !== 1'b0)
         $display("FAIL load_use_x0: got %b, required 0", full_stall);
      else n_pass++;
      tick();
      set_in(1'b0, 1'b1, 5'd9, 5'd9, 5'd2, 1'b0);
      n_checks++;
      if (full_stall !== 1'b1)
         $display("FAIL load_use_rs1: got %b, required 1", full_stall);
      else n_pass++;
      tick();
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      n_checks++;
      if (stall_cycles !== 16'd4)
         $display("FAIL load_use_count: got %0d, required 4", stall_cycles);
      else n_pass++;
   endtask

   task automatic test_mem_jump();
      for (int c = 0; c < 12; c++) begin
         set_in(c == 5, 1'b0, 5'd0, 5'd0, 5'd0, (c >= 4) && (c <= 7));
         n_checks++;
         if ({jump_stall, full_stall} !== {(c == 8) || (c == 9), (c >= 4) && (c <= 7)})
            $display("FAIL mem_jump: cycle %0d got js/fs=%b, required %b%b", c,
                     {jump_stall, full_stall}, (c == 8) || (c == 9), (c >= 4) && (c <= 7));
         else n_pass++;
         tick();
      end
      n_checks++;
      if (stall_cycles !== 16'd10)
         $display("FAIL mem_jump_count: got %0d, required 10", stall_cycles);
      else n_pass++;
   endtask

   task automatic test_jump_beats_lu();
      for (int c = 0; c < 3; c++) tick();
      set_in(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0);
      n_checks++;
      if ({jump_stall, full_stall} !== 2'b10)
         $display("FAIL jump_beats_lu: got js/fs=%b, required 10", {jump_stall, full_stall});
      else n_pass++;
      tick();
      set_in(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0);
      n_checks++;
      if ({jump_stall, full_stall} !== 2'b10)
         $display("FAIL lu_ignored_in_jump: got js/fs=%b, required 10", {jump_stall, full_stall});
      else n_pass++;
      tick();
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
   endtask

   task automatic test_reset_mid();
      set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({jump_stall, full_stall, stall_cycles} !== 18'd0)
         $display("FAIL reset_mid_jump: got js/fs=%b count=%0d, required 00 count=0",
                  {jump_stall, full_stall}, stall_cycles);
      else n_pass++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (jump_stall !== 1'b0)
         $display("FAIL after_reset_jump: got %b, required 0", jump_stall);
      else n_pass++;
      tick();
      set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      tick();
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({jump_stall, full_stall} !== 2'b00)
         $display("FAIL after_reset_memwait: got js/fs=%b, required 00", {jump_stall, full_stall});
      else n_pass++;
      tick();
      n_checks++;
      if (stall_cycles !== 16'd0)
         $display("FAIL after_reset_count: got %0d, required 0", stall_cycles);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int c = 0; c < 600; c++) begin
         set_in($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                AW'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
         model_eval();
         n_checks++;
         if ({jump_stall, full_stall} !== {e_js, e_fs}) begin
            if (errs < 10)
               $display("FAIL random_outputs: cycle %0d got js/fs=%b, required %b%b", c,
                        {jump_stall, full_stall}, e_js, e_fs);
            errs++;
         end else n_pass++;
         tick();
         n_checks++;
         if (stall_cycles !== 16'(m_count)) begin
            if (errs < 10)
               $display("FAIL random_count: cycle %0d got %0d, required %0d", c, stall_cycles, m_count);
            errs++;
         end else n_pass++;
      end
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      for (int c = 0; c < 20; c++) tick();
   endtask

   task automatic test_saturation();
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      for (int c = 0; c < 65700; c++) tick();
      n_checks++;
      if (stall_cycles !== 16'hFFFF)
         $display("FAIL saturate: got %0d, required 65535", stall_cycles);
      else n_pass++;
      n_checks++;
      if (full_stall !== 1'b1)
         $display("FAIL saturate_fs: got %b, required 1", full_stall);
      else n_pass++;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if ({jump_stall, full_stall, stall_cycles} !== 18'd0)
         $display("FAIL saturate_reset: got js/fs=%b count=%0d, required 00 count=0",
                  {jump_stall, full_stall}, stall_cycles);
      else n_pass++;
      @(posedge clk);
      #1;
      set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if ({jump_stall, full_stall} !== 2'b00)
         $display("FAIL saturate_release: got js/fs=%b, required 00", {jump_stall, full_stall});
      else n_pass++;
      tick();
      n_checks++;
      if (stall_cycles !== 16'd0)
         $display("FAIL saturate_release_count: got %0d, required 0", stall_cycles);
      else n_pass++;
   endtask

   initial begin
      model_reset();
      e_js = 1'b0;
      e_fs = 1'b0;
      #2;
      test_reset();
      test_jump_pulse();
      test_load_use();
      test_mem_jump();
      test_jump_beats_lu();
      test_reset_mid();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
